// File: rtl/out_display_pkg.sv
// Shared types and constants for the OUT register display block.
// Segment patterns are active-low, bit 0 = a through bit 6 = g.
package out_display_pkg;

    localparam int BCD_W = 4;
    localparam int STEPS = 8;
    localparam int STEP_CNT_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [BCD_W-1:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/out_display_bin_to_bcd.sv
// Sequential double-dabble converter, one shift step per clock.
// o_DONE strobes on the edge that completes the final step.
module bin_to_bcd
    import out_display_pkg::*;
(
    input  logic               i_CLOCK,
    input  logic               i_RESET,
    input  logic               i_START,
    input  logic [STEPS-1:0]   i_BIN,
    output logic               o_BUSY,
    output logic               o_DONE,
    output logic [BCD_W-1:0]   o_HUNDREDS,
    output logic [BCD_W-1:0]   o_TENS,
    output logic [BCD_W-1:0]   o_ONES
);

    state_t                  state;
    logic [STEP_CNT_W-1:0]   step_cnt;
    logic [STEPS-1:0]        shift_reg;
    logic [3*BCD_W-1:0]      bcd;
    logic [3*BCD_W-1:0]      bcd_adj;
    logic [3*BCD_W-1:0]      bcd_next;
    logic                    last_step;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*BCD_W +: BCD_W] >= 4'd5) begin
                bcd_adj[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[3*BCD_W-2:0], shift_reg[STEPS-1]};
    end

    assign last_step = (state == CONVERT) &&
                       (step_cnt == STEP_CNT_W'(STEPS - 1));

    // A new start on the final edge aborts, so no stale result is offered.
    assign o_DONE     = last_step && !i_START;
    assign o_HUNDREDS = bcd_next[3*BCD_W-1:2*BCD_W];
    assign o_TENS     = bcd_next[2*BCD_W-1:BCD_W];
    assign o_ONES     = bcd_next[BCD_W-1:0];

    always_ff @(posedge i_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            state     <= IDLE;
            o_BUSY    <= 1'b0;
            step_cnt  <= '0;
            shift_reg <= '0;
            bcd       <= '0;
        end else if (i_START) begin
            state     <= CONVERT;
            o_BUSY    <= 1'b1;
            step_cnt  <= '0;
            shift_reg <= i_BIN;
            bcd       <= '0;
        end else if (state == CONVERT) begin
            bcd       <= bcd_next;
            shift_reg <= {shift_reg[STEPS-2:0], 1'b0};
            if (last_step) begin
                state    <= IDLE;
                o_BUSY   <= 1'b0;
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_display.sv
// OUT register with BCD conversion and a 4-digit multiplexed 7-seg scan.
// Define OUT_DISPLAY_SIGNED_EN to show the value as two's complement.
module out_display
    import out_display_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int REFRESH_DIV = 1024
)
(
    input  logic                  i_CLOCK,
    input  logic                  i_RESET,
    input  logic [DATA_WIDTH-1:0] i_BUS_DATA,
    input  logic                  i_OUT_IN,
    output logic [DATA_WIDTH-1:0] o_VALUE,
    output logic                  o_BUSY,
    output logic [3:0]            o_DIGIT_SEL,
    output logic [6:0]            o_SEG
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [DATA_WIDTH-1:0] mag;
    logic                  neg_in;
    logic                  neg_pend;
    logic                  conv_done;
    logic [BCD_W-1:0]      res_h;
    logic [BCD_W-1:0]      res_t;
    logic [BCD_W-1:0]      res_o;
    logic [BCD_W-1:0]      disp_h;
    logic [BCD_W-1:0]      disp_t;
    logic [BCD_W-1:0]      disp_o;
    logic                  disp_neg;
    logic [CNT_W-1:0]      refresh_cnt;

`ifdef OUT_DISPLAY_SIGNED_EN
    assign neg_in = i_BUS_DATA[DATA_WIDTH-1];
    assign mag    = neg_in ? -i_BUS_DATA : i_BUS_DATA;
`else
    assign neg_in = 1'b0;
    assign mag    = i_BUS_DATA;
`endif

    bin_to_bcd u_bcd (
        .i_CLOCK    (i_CLOCK),
        .i_RESET    (i_RESET),
        .i_START    (i_OUT_IN),
        .i_BIN      (mag),
        .o_BUSY     (o_BUSY),
        .o_DONE     (conv_done),
        .o_HUNDREDS (res_h),
        .o_TENS     (res_t),
        .o_ONES     (res_o)
    );

    always_ff @(posedge i_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            o_VALUE  <= '0;
            neg_pend <= 1'b0;
        end else if (i_OUT_IN) begin
            o_VALUE  <= i_BUS_DATA;
            neg_pend <= neg_in;
        end
    end

    // Digits move only on completion so the scan never shows partial BCD.
    always_ff @(posedge i_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            disp_h   <= '0;
            disp_t   <= '0;
            disp_o   <= '0;
            disp_neg <= 1'b0;
        end else if (conv_done) begin
            disp_h   <= res_h;
            disp_t   <= res_t;
            disp_o   <= res_o;
            disp_neg <= neg_pend;
        end
    end

    always_ff @(posedge i_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            refresh_cnt <= '0;
            o_DIGIT_SEL <= 4'b0001;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            o_DIGIT_SEL <= {o_DIGIT_SEL[2:0], o_DIGIT_SEL[3]};
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        o_SEG = SEG_BLANK;
        unique case (1'b1)
            o_DIGIT_SEL[0]: o_SEG = seg_encode(disp_o);
            o_DIGIT_SEL[1]: o_SEG = (disp_h == '0 && disp_t == '0) ?
                                    SEG_BLANK : seg_encode(disp_t);
            o_DIGIT_SEL[2]: o_SEG = (disp_h == '0) ?
                                    SEG_BLANK : seg_encode(disp_h);
            o_DIGIT_SEL[3]: o_SEG = disp_neg ? SEG_MINUS : SEG_BLANK;
            default:        o_SEG = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display with a short refresh period.
// Expectations follow whether OUT_DISPLAY_SIGNED_EN is defined.
module tb_out_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [7:0] bus;
    logic       out_in;
    logic [7:0] value;
    logic       busy;
    logic [3:0] dsel;
    logic [6:0] seg;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] d;
        logic [6:0] h;
        logic [6:0] t;
        logic [6:0] o;
        logic [6:0] s;
    } vec_t;

    vec_t vt[7];

    out_display #(.DATA_WIDTH(8), .REFRESH_DIV(4)) dut (
        .i_CLOCK     (clk),
        .i_RESET     (rst),
        .i_BUS_DATA  (bus),
        .i_OUT_IN    (out_in),
        .o_VALUE     (value),
        .o_BUSY      (busy),
        .o_DIGIT_SEL (dsel),
        .o_SEG       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] d);
        @(negedge clk);
        bus    = d;
        out_in = 1'b1;
        @(negedge clk);
        out_in = 1'b0;
    endtask

    // Called at the negedge after a load edge; returns busy cycle count.
    task automatic busy_len(output int n, output logic hund_seen);
        n = 0;
        hund_seen = 1'b0;
        while (busy && n < 30) begin
            if (dsel[2] && seg !== SB) hund_seen = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_digit(input int idx, output logic [6:0] s);
        int n;
        n = 0;
        while (dsel !== 4'(1 << idx) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (dsel !== 4'(1 << idx)) begin
            n_tests++;
            n_fail++;
            $display("FAIL scan_timeout digit %0d sel %b", idx, dsel);
        end
        s = seg;
    endtask

    initial begin
        int         n;
        logic       hs;
        logic [6:0] sh, st, so, ss;

        vt[0] = '{8'hFF, S2, S5, S5, SB};
        vt[1] = '{8'h07, SB, SB, S7, SB};
        vt[2] = '{8'h00, SB, SB, S0, SB};
        vt[3] = '{8'h2A, SB, S4, S2, SB};
`ifdef OUT_DISPLAY_SIGNED_EN
        vt[4] = '{8'h80, S1, S2, S8, SM};
        vt[5] = '{8'hF6, SB, S1, S0, SM};
`else
        vt[4] = '{8'h80, S1, S2, S8, SB};
        vt[5] = '{8'hF6, S2, S4, S6, SB};
`endif
        vt[6] = '{8'h0A, SB, S1, S0, SB};

        rst    = 1'b1;
        bus    = 8'h00;
        out_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_value", value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", dsel, 4'b0001);
        chk("rst_seg", seg, S0);
        rst = 1'b0;

        // Scan rotation every 4 clocks from reset release.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 3) chk("scan_k3", dsel, 4'b0001);
            if (k == 4) chk("scan_k4", dsel, 4'b0010);
            if (k == 8) chk("scan_k8", dsel, 4'b0100);
            if (k == 12) chk("scan_k12", dsel, 4'b1000);
            if (k == 16) chk("scan_k16", dsel, 4'b0001);
        end

        for (int i = 0; i < 7; i++) begin
            do_load(vt[i].d);
            chk($sformatf("value_%0h", vt[i].d), value, vt[i].d);
            busy_len(n, hs);
            chk($sformatf("busy_len_%0h", vt[i].d), n, 8);
            read_digit(0, so);
            read_digit(1, st);
            read_digit(2, sh);
            read_digit(3, ss);
            chk($sformatf("ones_%0h", vt[i].d), so, vt[i].o);
            chk($sformatf("tens_%0h", vt[i].d), st, vt[i].t);
            chk($sformatf("hund_%0h", vt[i].d), sh, vt[i].h);
            chk($sformatf("sign_%0h", vt[i].d), ss, vt[i].s);
        end

        // Reload three cycles into a conversion of 100.
        @(negedge clk);
        bus    = 8'h64;
        out_in = 1'b1;
        @(negedge clk);
        out_in = 1'b0;
        @(negedge clk);
        chk("abort_busy1", busy, 1);
        @(negedge clk);
        chk("abort_busy2", busy, 1);
        bus    = 8'h05;
        out_in = 1'b1;
        @(negedge clk);
        out_in = 1'b0;
        chk("abort_value", value, 8'h05);
        busy_len(n, hs);
        chk("abort_busy_len", n, 8);
        chk("abort_no_100", hs, 0);
        read_digit(0, so);
        read_digit(1, st);
        read_digit(2, sh);
        chk("abort_ones", so, S5);
        chk("abort_tens", st, SB);
        chk("abort_hund", sh, SB);

        // Reset in the middle of converting 200.
        do_load(8'hC8);
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_value", value, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sel", dsel, 4'b0001);
        chk("mid_rst_seg", seg, S0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_value", value, 0);
        read_digit(0, so);
        chk("post_rst_ones", so, S0);
        read_digit(2, sh);
        chk("post_rst_hund", sh, SB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
